// File: rtl/recip_table_writer_if.sv
// Control and RAM-port bundle of the reciprocal table writer.
// The readback signals exist only when RECIP_READBACK_CHECK_EN is defined.
interface recip_table_writer_if #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  wr_en;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
`ifdef RECIP_READBACK_CHECK_EN
  logic [ADDR_BITS-1:0]  rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  chk_err;
`endif

  modport master (
    input  start,
    output busy, done, wr_en, wr_addr, wr_data
`ifdef RECIP_READBACK_CHECK_EN
    , output rd_addr, chk_err
    , input  rd_data
`endif
  );

  modport slave (
    output start,
    input  busy, done, wr_en, wr_addr, wr_data
`ifdef RECIP_READBACK_CHECK_EN
    , input  rd_addr, chk_err
    , output rd_data
`endif
  );
endinterface

// File: rtl/recip_table_writer.sv
// Generates the Goldschmidt seed table floor(2^(A+W-1)/(2^A+k)) by restoring division
// and writes it to RAM; RECIP_READBACK_CHECK_EN adds a checksum readback sweep.
module recip_table_writer #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  recip_table_writer_if.master bus
);
  localparam int RW = ADDR_BITS + 2;
  localparam int CW = $clog2(DATA_WIDTH);
  // Dividend bits above the quotient window; always below the divisor, so no overflow.
  localparam logic [RW-1:0]        REM_INIT = RW'(1) << (ADDR_BITS - 1);
  localparam logic [ADDR_BITS-1:0] K_LAST   = {ADDR_BITS{1'b1}};
  localparam logic [ADDR_BITS-1:0] K_ONE    = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_DIV, S_WRITE, S_CHECK, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  k_q, k_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [RW-1:0]         rem_shift;
  logic [RW-1:0]         divisor;
  logic                  q_bit;
  logic [DATA_WIDTH-1:0] quot_next;
`ifdef RECIP_READBACK_CHECK_EN
  localparam logic [ADDR_BITS:0] CHK_LAST = {1'b1, {ADDR_BITS{1'b0}}};
  logic [DATA_WIDTH-1:0] wr_sum_q, wr_sum_d;
  logic [DATA_WIDTH-1:0] rd_sum_q, rd_sum_d;
  logic [DATA_WIDTH-1:0] rd_sum_acc;
  logic [ADDR_BITS:0]    chk_cnt_q, chk_cnt_d;
  logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
  logic                  chk_err_q, chk_err_d;
`endif

  // One restoring-division step against divisor {1, k}.
  always_comb begin
    rem_shift = rem_q << 1;
    divisor   = {1'b0, 1'b1, k_q};
    q_bit     = (rem_shift >= divisor);
    quot_next = (quot_q << 1) | DATA_WIDTH'(q_bit);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    bit_cnt_d = bit_cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    busy_d    = busy_q;
    done_d    = done_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef RECIP_READBACK_CHECK_EN
    wr_sum_d   = wr_sum_q;
    rd_sum_d   = rd_sum_q;
    rd_sum_acc = rd_sum_q;
    chk_cnt_d  = chk_cnt_q;
    rd_addr_d  = rd_addr_q;
    chk_err_d  = chk_err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_DIV;
          k_d       = {ADDR_BITS{1'b0}};
          bit_cnt_d = {CW{1'b0}};
          rem_d     = REM_INIT;
          quot_d    = {DATA_WIDTH{1'b0}};
          busy_d    = 1'b1;
          done_d    = 1'b0;
`ifdef RECIP_READBACK_CHECK_EN
          wr_sum_d  = {DATA_WIDTH{1'b0}};
          chk_err_d = 1'b0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      S_DIV: begin
        rem_d  = q_bit ? (rem_shift - divisor) : rem_shift;
        quot_d = quot_next;
        if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = k_q;
          wr_data_d = quot_next;
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end
      S_WRITE: begin
`ifdef RECIP_READBACK_CHECK_EN
        wr_sum_d = wr_sum_q + wr_data_q;
`endif
        if (k_q == K_LAST) begin
`ifdef RECIP_READBACK_CHECK_EN
          state_d   = S_CHECK;
          chk_cnt_d = {(ADDR_BITS+1){1'b0}};
          rd_addr_d = {ADDR_BITS{1'b0}};
          rd_sum_d  = {DATA_WIDTH{1'b0}};
`else
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else begin
          state_d   = S_DIV;
          k_d       = k_q + K_ONE;
          bit_cnt_d = {CW{1'b0}};
          rem_d     = REM_INIT;
        end
      end
      S_CHECK: begin
`ifdef RECIP_READBACK_CHECK_EN
        // rd_data lags rd_addr by one cycle, so the first sample arrives at count 1.
        if (chk_cnt_q != {(ADDR_BITS+1){1'b0}}) begin
          rd_sum_acc = rd_sum_q + bus.rd_data;
        end else begin
          rd_sum_acc = rd_sum_q;
        end
        rd_sum_d = rd_sum_acc;
        if (chk_cnt_q == CHK_LAST) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          chk_err_d = (rd_sum_acc != wr_sum_q);
        end else begin
          chk_cnt_d = chk_cnt_q + {{ADDR_BITS{1'b0}}, 1'b1};
          rd_addr_d = chk_cnt_q[ADDR_BITS-1:0] + K_ONE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= {ADDR_BITS{1'b0}};
      bit_cnt_q <= {CW{1'b0}};
      rem_q     <= {RW{1'b0}};
      quot_q    <= {DATA_WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {ADDR_BITS{1'b0}};
      wr_data_q <= {DATA_WIDTH{1'b0}};
`ifdef RECIP_READBACK_CHECK_EN
      wr_sum_q  <= {DATA_WIDTH{1'b0}};
      rd_sum_q  <= {DATA_WIDTH{1'b0}};
      chk_cnt_q <= {(ADDR_BITS+1){1'b0}};
      rd_addr_q <= {ADDR_BITS{1'b0}};
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      bit_cnt_q <= bit_cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef RECIP_READBACK_CHECK_EN
      wr_sum_q  <= wr_sum_d;
      rd_sum_q  <= rd_sum_d;
      chk_cnt_q <= chk_cnt_d;
      rd_addr_q <= rd_addr_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
`ifdef RECIP_READBACK_CHECK_EN
  assign bus.rd_addr = rd_addr_q;
  assign bus.chk_err = chk_err_q;
`endif
endmodule

// File: tb/tb_recip_table_writer.sv
// Bench for recip_table_writer: RAM model, reciprocal reference by plain division,
// randomized timing of idle gaps, spurious starts and mid-run reset.
module tb_recip_table_writer;
  localparam int A = 10;
  localparam int W = 16;
  localparam int N = 1 << A;
  localparam int PERIOD = W + 1;
`ifdef RECIP_READBACK_CHECK_EN
  localparam int DONE_EDGE = PERIOD * N + N + 1;
`else
  localparam int DONE_EDGE = PERIOD * N;
`endif

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  logic [W-1:0] ram [0:N-1];
  bit   corrupt;

  recip_table_writer_if #(.ADDR_BITS(A), .DATA_WIDTH(W)) bus ();
  recip_table_writer #(.ADDR_BITS(A), .DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM write port, plus a registered read port that can corrupt address 7.
  always @(posedge clk) begin
    if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
`ifdef RECIP_READBACK_CHECK_EN
    bus.rd_data <= (corrupt && bus.rd_addr == 10'd7) ? (ram[bus.rd_addr] ^ 16'h0001) : ram[bus.rd_addr];
`endif
  end

  function automatic logic [31:0] recip(input int k);
    longint num;
    num = longint'(1) << (A + W - 1);
    return 32'(num / (longint'(N) + longint'(k)));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a run; checks every write against the reference and the completion timing.
  // abort_entry >= 0 resets the DUT during that entry's division instead.
  task automatic run_table(input int spur_at, input int abort_entry, input bit exp_err);
    int writes;
    int n;
    int abort_at;
    bit finished;
    writes = 0;
    finished = 1'b0;
    abort_at = (abort_entry >= 0) ? PERIOD * abort_entry + int'($urandom_range(0, 14)) : -1;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    check("done_after_start", {31'd0, bus.done}, 32'd0);
    for (n = 1; n <= DONE_EDGE + 50; n++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.wr_en) begin
        check("wr_edge", n + 1, PERIOD * (writes + 1));
        check("wr_addr", {22'd0, bus.wr_addr}, writes);
        check("wr_data", {16'd0, bus.wr_data}, recip(writes));
        writes++;
      end
      if (n == spur_at) bus.start = 1'b1;
      if (n == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_wr_en", {31'd0, bus.wr_en}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_writes", writes, abort_entry);
        return;
      end
      if (bus.done) begin
        finished = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, finished}, 32'd1);
    check("done_edge", n, DONE_EDGE);
    check("write_count", writes, N);
    check("busy_at_done", {31'd0, bus.busy}, 32'd0);
`ifdef RECIP_READBACK_CHECK_EN
    check("chk_err", {31'd0, bus.chk_err}, {31'd0, exp_err});
`else
    check("exp_err_unused", {31'd0, exp_err}, 32'd0);
`endif
  endtask

  initial begin
    int gap;
    int spur;
    int bad;
    compared = 0;
    mismatched = 0;
    corrupt = 1'b0;
    bus.start = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("rst_wr_addr", {22'd0, bus.wr_addr}, 32'd0);
    check("rst_wr_data", {16'd0, bus.wr_data}, 32'd0);
`ifdef RECIP_READBACK_CHECK_EN
    check("rst_rd_addr", {22'd0, bus.rd_addr}, 32'd0);
    check("rst_chk_err", {31'd0, bus.chk_err}, 32'd0);
`endif
    bus.start = 1'b0;
    rst = 1'b0;

    gap = int'($urandom_range(1, 20));
    repeat (gap) @(posedge clk);
    #1;
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("idle_wr_en", {31'd0, bus.wr_en}, 32'd0);

    // Full run with a spurious start near cycle 5000.
    spur = int'($urandom_range(4900, 5100));
    run_table(spur, -1, 1'b0);
    check("ram_0", {16'd0, ram[0]}, 32'h8000);
    check("ram_1", {16'd0, ram[1]}, 32'h7FE0);
    check("ram_512", {16'd0, ram[512]}, 32'h5555);
    check("ram_1023", {16'd0, ram[1023]}, 32'h4008);
    bad = 0;
    for (int k = 0; k < N; k++) begin
      if (32'(ram[k]) !== recip(k)) bad++;
    end
    check("ram_all_entries_bad", bad, 0);

    repeat (int'($urandom_range(3, 10))) @(posedge clk);
    #1;
    check("done_held", {31'd0, bus.done}, 32'd1);
    check("done_wr_en", {31'd0, bus.wr_en}, 32'd0);

    // Restart from DONE, then reset during entry 300's division.
    run_table(-1, 300, 1'b0);
    repeat (int'($urandom_range(1, 5))) @(posedge clk);
    #1;
    check("post_abort_busy", {31'd0, bus.busy}, 32'd0);

`ifdef RECIP_READBACK_CHECK_EN
    corrupt = 1'b1;
    run_table(-1, -1, 1'b1);
`else
    run_table(-1, -1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/recip_table_writer.md
Name: recip_table_writer

Overview:
- Sequential generator that computes the Goldschmidt initial-reciprocal table and writes it into a 1024x16 RAM through a write port.
- Replaces the offline-generated memory-init file; the divider's 1-cycle-latency lookup reads the RAM after the writer finishes.
- Entry k = floor(2^(ADDR_BITS+DATA_WIDTH-1) / (2^ADDR_BITS + k)), i.e. 1/d in Q1.15 for d = 1 + k/1024 in [1,2).
- Runs once per start pulse. Busy/done flags gate the divider.

Parameters:
- ADDR_BITS, 10, table address width; the table has 2^ADDR_BITS entries.
- DATA_WIDTH, 16, entry width; equals the number of quotient bits produced per entry.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to (re)generate the table
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  high once the table is complete; held until the next accepted start or rst
- wr_en  output  1  RAM write strobe, one cycle per entry
- wr_addr  output  ADDR_BITS  RAM write address
- wr_data  output  DATA_WIDTH  RAM write data
- rd_addr  output  ADDR_BITS  RAM read address (only when READBACK_CHECK_EN is defined)
- rd_data  input  DATA_WIDTH  RAM read data, registered 1 cycle after rd_addr (only when READBACK_CHECK_EN is defined)
- chk_err  output  1  readback checksum mismatch (only when READBACK_CHECK_EN is defined)

Behaviour:
- Reset (synchronous, active-high):
  - busy=0, done=0, wr_en=0, wr_addr=0, wr_data=0, chk_err=0, rd_addr=0.
  - FSM goes to IDLE.
  - Reset mid-run aborts immediately. RAM keeps any partially written contents; no rollback.
- FSM states: IDLE, DIV, WRITE, (CHECK when the feature is enabled), DONE.
- IDLE/DONE + start=1 -> DIV with k=0, busy=1, done=0. start is ignored while busy=1.
- DIV: restoring division, one quotient bit per cycle, MSB first, for exactly DATA_WIDTH cycles.
  - Divisor = {1'b1, k} (ADDR_BITS+1 bits).
  - Dividend = 2^(ADDR_BITS+DATA_WIDTH-1).
  - Remainder register is ADDR_BITS+2 bits; no rounding (floor).
- WRITE: one cycle with wr_en=1, wr_addr=k, wr_data=quotient.
  - If k == 2^ADDR_BITS-1 -> CHECK if enabled, else DONE.
  - Otherwise k+1 -> DIV.
- Per-entry period is DATA_WIDTH+1 = 17 cycles. A full table completes 17*1024 = 17408 cycles after start is accepted.
- DONE: busy=0, done=1, wr_en=0. The next start restarts from k=0.
- wr_en is never high outside WRITE. wr_addr/wr_data are held between writes.
- Boundary values: k=0 -> 0x8000 (maximum, fits DATA_WIDTH unsigned); k=1023 -> 0x4008. No overflow is possible for any k.
- start coincident with rst: rst wins.

Optional Feature:
- Macro: RECIP_READBACK_CHECK_EN.
- Defined:
  - A 16-bit modulo sum of all wr_data values accumulates during WRITE.
  - After the last write, the FSM enters CHECK and sweeps rd_addr 0..1023, one address per cycle, capturing rd_data 1 cycle later. This takes 1025 cycles.
  - It accumulates a second modulo sum; on mismatch, chk_err=1.
  - done rises after the sweep. chk_err is held until the next accepted start or rst.
- Undefined: rd_addr, rd_data and chk_err do not exist; WRITE of the last entry goes straight to DONE.

Test Plan:
- Reset then start: first write at cycle 17 -> wr_addr=0, wr_data=0x8000. Second write at cycle 34 -> wr_addr=1, wr_data=0x7FE0.
- Full run into a RAM model: entry 512 = 0x5555, entry 1023 = 0x4008. All 1024 entries match the floor formula. done rises at cycle 17408, and exactly 1024 wr_en pulses occur.
- start pulsed while busy at cycle 5000 -> ignored; write sequence and done timing unchanged.
- rst asserted during entry 300's DIV -> next cycle busy=0, wr_en=0, done=0. A new start restarts at wr_addr=0.
- RECIP_READBACK_CHECK_EN, clean RAM model -> chk_err=0, done at 17408+1025 cycles.
- RECIP_READBACK_CHECK_EN, RAM model corrupting address 7 -> chk_err=1 at done.
